prog_sequencer: RTL and testbench



---
 rtl/prog_sequencer.sv | 144 ++++++++++++++
 tb/tb_prog_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// Programmable instruction sequencer: a writable opcode/operand store walked by its own
// program counter, presenting each instruction to the datapath over valid/ready.
module prog_sequencer #(
    parameter int OP_W   = 4,
    parameter int DATA_W = 5,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DEF_A  = 4,
    parameter int DEF_B  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [OP_W-1:0]   prog_op,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              start,
    input  logic              abort,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [OP_W-1:0]   instr_op,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done
);

    localparam logic [OP_W-1:0]   OP_CLEARLD = OP_W'(0);
    localparam logic [OP_W-1:0]   OP_ADDLD   = OP_W'(1);
    localparam logic [OP_W-1:0]   OP_ADD     = OP_W'(2);
    localparam logic [OP_W-1:0]   OP_SHTR    = OP_W'(3);
    localparam logic [OP_W-1:0]   OP_DISP    = OP_W'(4);
    localparam logic [OP_W-1:0]   OP_HALT    = {OP_W{1'b1}};
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_nextPc;
    logic                w_load;
    logic                w_progWrite;
    logic [OP_W-1:0]     r_instrOp;
    logic [DATA_W-1:0]   r_instrData;
    logic [OP_W-1:0]     r_memOp   [DEPTH];
    logic [DATA_W-1:0]   r_memData [DEPTH];
    logic [OP_W-1:0]     w_fetchOp;
    logic [DATA_W-1:0]   w_fetchData;

    assign w_fetchOp   = r_memOp[r_pc];
    assign w_fetchData = r_memData[r_pc];
    assign w_progWrite = prog_we && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Reset restores the built-in demo program; any user program is discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_memOp[i]   <= OP_HALT;
                r_memData[i] <= '0;
            end
            r_memOp[0]   <= OP_CLEARLD;
            r_memData[0] <= DATA_W'(DEF_A);
            r_memOp[1]   <= OP_ADDLD;
            r_memData[1] <= DATA_W'(DEF_B);
            r_memOp[2]   <= OP_ADD;
            r_memOp[3]   <= OP_SHTR;
            r_memOp[4]   <= OP_DISP;
        end else if (w_progWrite) begin
            r_memOp[prog_addr]   <= prog_op;
            r_memData[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_instrOp   <= '0;
            r_instrData <= '0;
        end else begin
            r_state <= w_nextState;
            r_pc    <= w_nextPc;
            if (w_load) begin
                r_instrOp   <= w_fetchOp;
                r_instrData <= w_fetchData;
            end
        end
    end

    // Abort overrides everything, including an accept or start in the same cycle.
    always_comb begin
        w_nextState = r_state;
        w_nextPc    = r_pc;
        w_load      = 1'b0;
        if (abort) begin
            w_nextState = S_IDLE;
            w_nextPc    = '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_nextState = S_FETCH;
                        w_nextPc    = '0;
                    end
                end
                S_FETCH: begin
                    if (w_fetchOp == OP_HALT) begin
                        w_nextState = S_DONE;
                    end else begin
                        w_load      = 1'b1;
                        w_nextState = S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (instr_ready) begin
                        if (r_pc == LAST_ADDR) begin
                            w_nextState = S_DONE;
                        end else begin
                            w_nextPc    = r_pc + ADDR_W'(1);
                            w_nextState = S_FETCH;
                        end
                    end
                end
                default: begin
                    w_nextState = S_IDLE;
                end
            endcase
        end
    end

    assign instr_valid = (r_state == S_PRESENT);
    assign instr_op    = r_instrOp;
    assign instr_data  = r_instrData;
    assign pc          = r_pc;
    assign busy        = (r_state == S_FETCH) || (r_state == S_PRESENT);
    assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: a program-array model predicts the presented
// instruction stream, and a negedge monitor checks accepts, holds and valid latency.
module tb_prog_sequencer;

    localparam int OP_W   = 4;
    localparam int DATA_W = 5;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int HALT   = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [OP_W-1:0]   prog_op;
    logic [DATA_W-1:0] prog_data;
    logic              start;
    logic              abort;
    logic              instr_valid;
    logic              instr_ready;
    logic [OP_W-1:0]   instr_op;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              done;

    prog_sequencer #(
        .OP_W(OP_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DEF_A(4), .DEF_B(2)
    ) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_op(prog_op),
        .prog_data(prog_data), .start(start), .abort(abort), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr_op(instr_op), .instr_data(instr_data), .pc(pc),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mOp   [DEPTH];
    int mData [DEPTH];
    int expQ  [$];
    int expPc;
    int readyMode;
    int holdCnt;
    int acceptCount;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic void loadDefaultModel();
        for (int i = 0; i < DEPTH; i++) begin
            mOp[i]   = HALT;
            mData[i] = 0;
        end
        mOp[0] = 0; mData[0] = 4;
        mOp[1] = 1; mData[1] = 2;
        mOp[2] = 2;
        mOp[3] = 3;
        mOp[4] = 4;
    endfunction

    // Walk the program from 0: every non-HALT entry is presented; stop on HALT or at the end.
    function automatic void pushExpected();
        expPc = 0;
        for (int a = 0; a < DEPTH; a++) begin
            expPc = a;
            if (mOp[a] == HALT) break;
            expQ.push_back(mOp[a] * 32 + mData[a]);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        case (readyMode)
            0: instr_ready = 1'b1;
            1: instr_ready = 1'($urandom_range(0, 1));
            2: begin
                if (acceptCount == 1 && instr_valid && holdCnt < 5) begin
                    instr_ready = 1'b0;
                    holdCnt++;
                end else begin
                    instr_ready = 1'b1;
                end
            end
            default: ;
        endcase
    endtask

    task automatic applyStimulus();
        start = 1'b1;
        pushExpected();
        tick();
        start = 1'b0;
    endtask

    task automatic writeEntry(input int a, input int op, input int d);
        prog_we   = 1'b1;
        prog_addr = ADDR_W'(a);
        prog_op   = OP_W'(op);
        prog_data = DATA_W'(d);
        tick();
        prog_we   = 1'b0;
        mOp[a]    = op;
        mData[a]  = d;
    endtask

    task automatic runUntilDone(input int budget, input string name);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        checkOutput({name, " done"}, int'(done), 1);
        checkOutput({name, " final pc"}, int'(pc), expPc);
        checkOutput({name, " leftover instrs"}, expQ.size(), 0);
        expQ.delete();
    endtask

    task automatic waitValid(input int budget, input string name);
        int n = 0;
        while (!instr_valid && n < budget) begin
            tick();
            n++;
        end
        checkOutput({name, " valid seen"}, int'(instr_valid), 1);
    endtask

    task automatic checkIdleOutputs(input string name);
        checkOutput({name, " valid"}, int'(instr_valid), 0);
        checkOutput({name, " pc"}, int'(pc), 0);
        checkOutput({name, " busy"}, int'(busy), 0);
        checkOutput({name, " done"}, int'(done), 0);
    endtask

    // Monitor: pops on each real accept, checks holds stay stable and valid rises 2 cycles after a trigger.
    int   sinceTrig = 100;
    logic prevValid = 1'b0;
    logic prevHold  = 1'b0;
    int   prevOp    = 0;
    int   prevData  = 0;
    always @(negedge clk) begin
        int expv;
        if (rst) begin
            prevValid = 1'b0;
            prevHold  = 1'b0;
            sinceTrig = 100;
        end else begin
            sinceTrig++;
            if (prevHold) begin
                checkOutput("held valid", int'(instr_valid), 1);
                checkOutput("held op", int'(instr_op), prevOp);
                checkOutput("held data", int'(instr_data), prevData);
            end
            if (instr_valid && !prevValid) checkOutput("valid latency", sinceTrig, 2);
            if (instr_valid && instr_ready && !abort) begin
                acceptCount++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected instr", int'(instr_op) * 32 + int'(instr_data), -1);
                end else begin
                    expv = expQ.pop_front();
                    checkOutput("instr", int'(instr_op) * 32 + int'(instr_data), expv);
                end
                sinceTrig = 0;
            end
            if (start && !abort && !busy && !instr_valid) sinceTrig = 0;
            prevHold  = instr_valid && !instr_ready && !abort;
            prevValid = instr_valid;
            prevOp    = int'(instr_op);
            prevData  = int'(instr_data);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_op = '0; prog_data = '0;
        start = 1'b0; abort = 1'b0; instr_ready = 1'b0;
        readyMode = 0; holdCnt = 0; acceptCount = 0;
        loadDefaultModel();
        repeat (2) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        checkOutput("reset op", int'(instr_op), 0);
        checkOutput("reset data", int'(instr_data), 0);
        rst = 1'b0;
        tick();

        $display("[TB] default program, ready tied high");
        readyMode = 0;
        applyStimulus();
        runUntilDone(100, "default");

        $display("[TB] ready held low on the second instruction");
        readyMode = 2; holdCnt = 0; acceptCount = 0;
        applyStimulus();
        runUntilDone(100, "stall");
        checkOutput("stall accept count", acceptCount, 5);

        $display("[TB] patched program with early HALT");
        readyMode = 0;
        writeEntry(2, 3, 7);
        writeEntry(3, HALT, 0);
        applyStimulus();
        runUntilDone(100, "patched");

        $display("[TB] full program, no wrap");
        for (int a = 0; a < DEPTH; a++) writeEntry(a, 2, a);
        applyStimulus();
        runUntilDone(200, "full");

        $display("[TB] write and start ignored while presenting");
        readyMode = 3; instr_ready = 1'b0;
        applyStimulus();
        waitValid(10, "ignore");
        prog_we = 1'b1; prog_addr = 4'd4; prog_op = 4'd3; prog_data = 5'd9; start = 1'b1;
        tick();
        prog_we = 1'b0; start = 1'b0;
        repeat (2) tick();
        readyMode = 0;
        runUntilDone(200, "ignore");

        $display("[TB] abort coincident with accept");
        readyMode = 3; instr_ready = 1'b0;
        applyStimulus();
        waitValid(10, "abort");
        instr_ready = 1'b1; abort = 1'b1;
        tick();
        abort = 1'b0; instr_ready = 1'b0;
        expQ.delete();
        checkIdleOutputs("abort");
        readyMode = 0;
        applyStimulus();
        runUntilDone(200, "after abort");

        $display("[TB] reset mid-run restores default program");
        writeEntry(0, 3, 9);
        readyMode = 1;
        applyStimulus();
        repeat (6) tick();
        rst = 1'b1;
        #1;
        expQ.delete();
        checkIdleOutputs("mid reset");
        checkOutput("mid reset op", int'(instr_op), 0);
        checkOutput("mid reset data", int'(instr_data), 0);
        tick();
        rst = 1'b0;
        loadDefaultModel();
        tick();
        applyStimulus();
        runUntilDone(200, "post reset");

        $display("[TB] random programs, random ready");
        for (int r = 0; r < 4; r++) begin
            readyMode = 0;
            for (int a = 0; a < DEPTH; a++) writeEntry(a, int'($urandom_range(0, 15)), int'($urandom_range(0, 31)));
            readyMode = 1;
            applyStimulus();
            runUntilDone(400, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
